// File: rtl/flits_sender_pkg.sv
// Shared constants, types and helpers for the NIC flit transmit path.
package flits_sender_pkg;

   // Link geometry
   localparam int FLIT_WIDTH        = 64;
   localparam int MAX_PACKET_LENGHT = 8;

   // Flit type lives in the two LSBs of every flit
   localparam int         FLIT_TYPE_BITS     = 2;
   localparam logic [1:0] FLIT_TYPE_HEAD     = 2'b00;
   localparam logic [1:0] FLIT_TYPE_BODY     = 2'b01;
   localparam logic [1:0] FLIT_TYPE_TAIL     = 2'b10;
   localparam logic [1:0] FLIT_TYPE_HEADTAIL = 2'b11;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_e;

   // Ceiling log2, usable in parameter expressions
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 << i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   // A flit closes its packet when it is a tail or a single-flit packet
   function automatic logic is_closing_type(input logic [FLIT_TYPE_BITS-1:0] t);
      return (t == FLIT_TYPE_TAIL) || (t == FLIT_TYPE_HEADTAIL);
   endfunction

endpackage

// File: rtl/flits_sender_credit_counter.sv
// Downstream credit tracker: one credit per free slot in the receive buffer.
// Saturates at N_CREDITS; an overflowing credit sets a sticky error flag.
module credit_counter
   import flits_sender_pkg::*;
#(
   parameter int N_CREDITS     = 4,
   parameter int N_BITS_CREDIT = clog2(N_CREDITS + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     inc_i,
   input  logic                     dec_i,
   output logic [N_BITS_CREDIT-1:0] count_o,
   output logic                     has_credit_o,
   output logic                     err_o
);

   localparam logic [N_BITS_CREDIT-1:0] FULL = N_BITS_CREDIT'(N_CREDITS);
   localparam logic [N_BITS_CREDIT-1:0] ONE  = N_BITS_CREDIT'(1);
   localparam logic [N_BITS_CREDIT-1:0] ZERO = N_BITS_CREDIT'(0);

   logic [N_BITS_CREDIT-1:0] count_q, count_d;
   logic                     err_q, err_d;

   // Next credit count: a simultaneous credit and send cancel out
   always_comb begin
      count_d = count_q;
      err_d   = err_q;
      case ({inc_i, dec_i})
         2'b10: begin
            if (count_q == FULL) begin
               err_d = 1'b1;
            end else begin
               count_d = count_q + ONE;
            end
         end
         2'b01: begin
            if (count_q != ZERO) begin
               count_d = count_q - ONE;
            end else begin
               count_d = count_q;
            end
         end
         default: begin
            count_d = count_q;
         end
      endcase
   end

   // Credit and error state registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= FULL;
         err_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   assign count_o      = count_q;
   assign has_credit_o = (count_q != ZERO);
   assign err_o        = err_q;

endmodule

// File: rtl/flits_sender.sv
// Transmit side of the NIC link: latches a whole packet on request/grant and
// serialises it one flit per cycle while downstream credits are available.
module flits_sender
   import flits_sender_pkg::*;
#(
   parameter int N_CREDITS      = 4,
   parameter int N_BITS_CREDIT  = clog2(N_CREDITS + 1),
   parameter int N_BITS_POINTER = clog2(MAX_PACKET_LENGHT)
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] in_link_i,
   input  logic                                  r_msg_to_pkt_i,
   output logic                                  g_msg_to_pkt_o,
   input  logic                                  credit_signal_i,
   output logic [FLIT_WIDTH-1:0]                 out_link_o,
   output logic                                  is_valid_o,
   output logic                                  busy_o,
   output logic                                  credit_err_o
);

   localparam logic [N_BITS_POINTER-1:0] PTR_LAST = N_BITS_POINTER'(MAX_PACKET_LENGHT - 1);
   localparam logic [N_BITS_POINTER-1:0] PTR_ONE  = N_BITS_POINTER'(1);
   localparam logic [N_BITS_POINTER-1:0] PTR_ZERO = N_BITS_POINTER'(0);

   state_e                                        state_q;
   logic [MAX_PACKET_LENGHT-1:0][FLIT_WIDTH-1:0]  pkt_q;
   logic [N_BITS_POINTER-1:0]                     ptr_q;
   logic                                          grant_q;
   logic                                          valid_q;
   logic [FLIT_WIDTH-1:0]                         out_q;

   logic [FLIT_WIDTH-1:0]    cur_flit_s;
   logic                     last_flit_s;
   logic                     send_s;
   logic                     has_credit_s;
   logic [N_BITS_CREDIT-1:0] count_s;

   credit_counter #(
      .N_CREDITS     (N_CREDITS),
      .N_BITS_CREDIT (N_BITS_CREDIT)
   ) u_credit (
      .clk          (clk),
      .rst          (rst),
      .inc_i        (credit_signal_i),
      .dec_i        (send_s),
      .count_o      (count_s),
      .has_credit_o (has_credit_s),
      .err_o        (credit_err_o)
   );

   // Flit mux and end-of-packet detection (tail type or max length reached)
   always_comb begin
      cur_flit_s  = pkt_q[ptr_q];
      last_flit_s = 1'b0;
      send_s      = 1'b0;
      if (state_q == S_SEND) begin
         send_s      = has_credit_s;
         last_flit_s = is_closing_type(cur_flit_s[FLIT_TYPE_BITS-1:0]) || (ptr_q == PTR_LAST);
      end else begin
         send_s      = 1'b0;
         last_flit_s = 1'b0;
      end
   end

   // Packet FSM with registered grant and link outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         pkt_q   <= '0;
         ptr_q   <= PTR_ZERO;
         grant_q <= 1'b0;
         valid_q <= 1'b0;
         out_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               valid_q <= 1'b0;
               out_q   <= '0;
               grant_q <= r_msg_to_pkt_i;
               if (r_msg_to_pkt_i) begin
                  pkt_q   <= in_link_i;
                  ptr_q   <= PTR_ZERO;
                  state_q <= S_SEND;
               end
            end
            S_SEND: begin
               grant_q <= 1'b0;
               if (send_s) begin
                  out_q   <= cur_flit_s;
                  valid_q <= 1'b1;
                  if (last_flit_s) begin
                     ptr_q   <= PTR_ZERO;
                     state_q <= S_IDLE;
                  end else begin
                     ptr_q   <= ptr_q + PTR_ONE;
                  end
               end else begin
                  out_q   <= '0;
                  valid_q <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               grant_q <= 1'b0;
               valid_q <= 1'b0;
               out_q   <= '0;
               ptr_q   <= PTR_ZERO;
            end
         endcase
      end
   end

   assign g_msg_to_pkt_o = grant_q;
   assign is_valid_o     = valid_q;
   assign out_link_o     = out_q;
   assign busy_o         = (state_q == S_SEND);

endmodule

// File: tb/tb_flits_sender.sv
// Directed bench for flits_sender: grant latency, serialisation, credit flow,
// max-length truncation, request during send, async reset and credit overflow.
module tb_flits_sender;
   import flits_sender_pkg::*;

   logic                                         clk;
   logic                                         rst;
   logic [MAX_PACKET_LENGHT-1:0][FLIT_WIDTH-1:0] pkt;
   logic                                         req;
   logic                                         grant;
   logic                                         credit;
   logic [FLIT_WIDTH-1:0]                        out_link;
   logic                                         valid;
   logic                                         busy;
   logic                                         cerr;

   int checks;
   int errors;

   flits_sender dut (
      .clk             (clk),
      .rst             (rst),
      .in_link_i       (pkt),
      .r_msg_to_pkt_i  (req),
      .g_msg_to_pkt_o  (grant),
      .credit_signal_i (credit),
      .out_link_o      (out_link),
      .is_valid_o      (valid),
      .busy_o          (busy),
      .credit_err_o    (cerr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      req    = 1'b0;
      credit = 1'b0;
      rst    = 1'b0;
      step();
      rst    = 1'b1;
      step();
   endtask

   task automatic load_five();
      pkt    = '0;
      pkt[0] = 64'h00;
      pkt[1] = 64'h11;
      pkt[2] = 64'h21;
      pkt[3] = 64'h31;
      pkt[4] = 64'h72;
   endtask

   task automatic test_reset();
      pkt = '0;
      apply_reset();
      checks++; if (grant !== 1'b0) begin errors++; $display("FAIL rst_grant got %0b exp 0", grant); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", valid); end
      checks++; if (out_link !== 64'h0) begin errors++; $display("FAIL rst_out got %0h exp 0", out_link); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
      checks++; if (cerr !== 1'b0) begin errors++; $display("FAIL rst_err got %0b exp 0", cerr); end
      checks++; if (dut.count_s !== 3'd4) begin errors++; $display("FAIL rst_count got %0d exp 4", dut.count_s); end
   endtask

   task automatic test_single_flit();
      apply_reset();
      pkt    = '0;
      pkt[0] = 64'hFF3;
      req    = 1'b1;
      step();
      checks++; if (grant !== 1'b1) begin errors++; $display("FAIL sf_grant got %0b exp 1", grant); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL sf_valid_e0 got %0b exp 0", valid); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sf_busy_e0 got %0b exp 1", busy); end
      req = 1'b0;
      step();
      checks++; if (grant !== 1'b0) begin errors++; $display("FAIL sf_grant_e1 got %0b exp 0", grant); end
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL sf_valid got %0b exp 1", valid); end
      checks++; if (out_link !== 64'hFF3) begin errors++; $display("FAIL sf_out got %0h exp ff3", out_link); end
      checks++; if (dut.count_s !== 3'd3) begin errors++; $display("FAIL sf_count got %0d exp 3", dut.count_s); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sf_busy got %0b exp 0", busy); end
      step();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL sf_valid_e2 got %0b exp 0", valid); end
      checks++; if (out_link !== 64'h0) begin errors++; $display("FAIL sf_out_e2 got %0h exp 0", out_link); end
   endtask

   task automatic test_five_flits();
      logic [63:0] exp_f [5];
      exp_f = '{64'h00, 64'h11, 64'h21, 64'h31, 64'h72};
      apply_reset();
      load_five();
      req = 1'b1;
      step();
      req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ff_valid[%0d] got %0b exp 1", k, valid); end
         checks++; if (out_link !== exp_f[k]) begin errors++; $display("FAIL ff_out[%0d] got %0h exp %0h", k, out_link, exp_f[k]); end
      end
      checks++; if (dut.count_s !== 3'd0) begin errors++; $display("FAIL ff_count0 got %0d exp 0", dut.count_s); end
      step();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ff_stall_valid got %0b exp 0", valid); end
      checks++; if (out_link !== 64'h0) begin errors++; $display("FAIL ff_stall_out got %0h exp 0", out_link); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ff_stall_busy got %0b exp 1", busy); end
      credit = 1'b1;
      step();
      credit = 1'b0;
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ff_credit_valid got %0b exp 0", valid); end
      step();
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ff_tail_valid got %0b exp 1", valid); end
      checks++; if (out_link !== exp_f[4]) begin errors++; $display("FAIL ff_tail_out got %0h exp %0h", out_link, exp_f[4]); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ff_tail_busy got %0b exp 0", busy); end
   endtask

   task automatic test_simultaneous_credit();
      apply_reset();
      load_five();
      req = 1'b1;
      step();
      req = 1'b0;
      step();
      step();
      checks++; if (dut.count_s !== 3'd2) begin errors++; $display("FAIL sc_pre_count got %0d exp 2", dut.count_s); end
      credit = 1'b1;
      step();
      credit = 1'b0;
      checks++; if (out_link !== 64'h21 || valid !== 1'b1) begin errors++; $display("FAIL sc_flit2 got %0h/%0b exp 21/1", out_link, valid); end
      checks++; if (dut.count_s !== 3'd2) begin errors++; $display("FAIL sc_count got %0d exp 2", dut.count_s); end
      step();
      checks++; if (out_link !== 64'h31 || valid !== 1'b1) begin errors++; $display("FAIL sc_flit3 got %0h/%0b exp 31/1", out_link, valid); end
      step();
      checks++; if (out_link !== 64'h72 || valid !== 1'b1) begin errors++; $display("FAIL sc_flit4 got %0h/%0b exp 72/1", out_link, valid); end
      checks++; if (dut.count_s !== 3'd0) begin errors++; $display("FAIL sc_end_count got %0d exp 0", dut.count_s); end
   endtask

   task automatic test_max_length();
      logic [63:0] exp_v;
      apply_reset();
      for (int k = 0; k < MAX_PACKET_LENGHT; k++) begin
         pkt[k] = 64'(k * 16 + 1);
      end
      req = 1'b1;
      step();
      credit = 1'b1;
      for (int k = 0; k < MAX_PACKET_LENGHT; k++) begin
         step();
         exp_v = 64'(k * 16 + 1);
         checks++; if (valid !== 1'b1 || out_link !== exp_v) begin errors++; $display("FAIL ml_flit[%0d] got %0h/%0b exp %0h/1", k, out_link, valid, exp_v); end
      end
      credit = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ml_busy got %0b exp 0", busy); end
      checks++; if (grant !== 1'b0) begin errors++; $display("FAIL ml_grant_early got %0b exp 0", grant); end
      step();
      checks++; if (grant !== 1'b1) begin errors++; $display("FAIL ml_regrant got %0b exp 1", grant); end
      checks++; if (dut.count_s !== 3'd4 || cerr !== 1'b0) begin errors++; $display("FAIL ml_count got %0d/%0b exp 4/0", dut.count_s, cerr); end
      req = 1'b0;
   endtask

   task automatic test_req_in_send();
      apply_reset();
      pkt    = '0;
      pkt[0] = 64'h00;
      pkt[1] = 64'h12;
      req    = 1'b1;
      step();
      checks++; if (grant !== 1'b1) begin errors++; $display("FAIL rs_grant got %0b exp 1", grant); end
      step();
      checks++; if (grant !== 1'b0) begin errors++; $display("FAIL rs_grant_send got %0b exp 0", grant); end
      step();
      checks++; if (grant !== 1'b0 || out_link !== 64'h12) begin errors++; $display("FAIL rs_tail got %0b/%0h exp 0/12", grant, out_link); end
      step();
      checks++; if (grant !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL rs_regrant got %0b/%0b exp 1/0", grant, valid); end
      req = 1'b0;
   endtask

   task automatic test_reset_mid_packet();
      apply_reset();
      load_five();
      req = 1'b1;
      step();
      req = 1'b0;
      step();
      step();
      checks++; if (valid !== 1'b1 || out_link !== 64'h11) begin errors++; $display("FAIL rm_pre got %0b/%0h exp 1/11", valid, out_link); end
      rst = 1'b0;
      #1;
      checks++; if (valid !== 1'b0 || out_link !== 64'h0) begin errors++; $display("FAIL rm_valid got %0b/%0h exp 0/0", valid, out_link); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %0b exp 0", busy); end
      checks++; if (dut.count_s !== 3'd4) begin errors++; $display("FAIL rm_count got %0d exp 4", dut.count_s); end
      step();
      rst = 1'b1;
      step();
      checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_noflush got %0b/%0b exp 0/0", valid, busy); end
   endtask

   task automatic test_credit_overflow();
      apply_reset();
      credit = 1'b1;
      step();
      credit = 1'b0;
      checks++; if (cerr !== 1'b1) begin errors++; $display("FAIL co_err got %0b exp 1", cerr); end
      checks++; if (dut.count_s !== 3'd4) begin errors++; $display("FAIL co_count got %0d exp 4", dut.count_s); end
      step();
      step();
      checks++; if (cerr !== 1'b1) begin errors++; $display("FAIL co_sticky got %0b exp 1", cerr); end
      apply_reset();
      checks++; if (cerr !== 1'b0) begin errors++; $display("FAIL co_clear got %0b exp 0", cerr); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      req    = 1'b0;
      credit = 1'b0;
      pkt    = '0;
      test_reset();
      test_single_flit();
      test_five_flits();
      test_simultaneous_credit();
      test_max_length();
      test_req_in_send();
      test_reset_mid_packet();
      test_credit_overflow();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/flits_sender.md
Name: flits_sender

Overview:
- Transmit side of the NIC link protocol; mirror of the receive-side flits buffer.
- Accepts a whole packet, up to `MAX_PACKET_LENGHT flits wide, from the message-to-packet stage through a request/grant handshake.
- Serialises the packet onto the flit link one flit per cycle.
- Sends a flit only when it holds a credit for the downstream buffer.

Parameters:
- N_CREDITS, 4, downstream buffer slots; reset value of the credit counter.
- N_BITS_CREDIT, clog2(N_CREDITS+1), credit counter width.
- N_BITS_POINTER, clog2(`MAX_PACKET_LENGHT), flit index width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_link_i  input  `MAX_PACKET_LENGHT*`FLIT_WIDTH  packet; flit k occupies bits [(k+1)*`FLIT_WIDTH-1 : k*`FLIT_WIDTH]; flit 0 is the head.
- r_msg_to_pkt_i  input  1  request: a packet is valid on in_link_i; held high until granted.
- g_msg_to_pkt_o  output  1  grant: one-cycle pulse; the packet has been latched.
- credit_signal_i  input  1  one-cycle pulse = one downstream slot freed.
- out_link_o  output  `FLIT_WIDTH  flit to link.
- is_valid_o  output  1  out_link_o carries a valid flit this cycle.
- busy_o  output  1  high while a packet is held (state SEND).
- credit_err_o  output  1  sticky: credit received while the counter was already at N_CREDITS.

Behaviour:
- Flit type is in bits [1:0]: 00 head, 01 body, 10 tail, 11 head+tail (single-flit packet).
- Reset (rst=0, asynchronous): state IDLE, g_msg_to_pkt_o=0, is_valid_o=0, out_link_o=0, busy_o=0, credit_err_o=0, credit counter=N_CREDITS, pointer=0. All outputs are registered; a reset mid-packet discards the packet with no flush.
- FSM has two states, IDLE and SEND.
- IDLE:
  - On a clock edge with r_msg_to_pkt_i=1, latch in_link_i into the packet register, set pointer=0, and go to SEND.
  - g_msg_to_pkt_o is high for exactly the following cycle.
- SEND:
  - On each edge with credit counter>0: out_link_o=flit[pointer], is_valid_o=1, pointer++, counter--.
  - On each edge with counter=0: is_valid_o=0, out_link_o=0, pointer held.
- End of packet: if the flit sent has type tail or head+tail, or pointer=`MAX_PACKET_LENGHT-1, return to IDLE on the same edge. Flit contents are never modified; a malformed packet is truncated at max length.
- Latency: request sampled at edge E0 → grant high E0..E1 → flit 0 valid E1..E2 (given a credit).
- Throughput: one flit per cycle while credits last. At least one idle cycle between the tail and the next grant.
- Requests arriving in SEND are not granted; the upstream keeps the request high.
- Credit counter:
  - Credit pulse with no send in the same cycle: +1.
  - Send with no credit pulse: -1.
  - Credit pulse and send in the same cycle: unchanged.
  - Credit pulse with counter=N_CREDITS and no send: counter saturates and credit_err_o is set until reset.
  - The counter updates in every state.
- When is_valid_o=0, out_link_o=0.
- busy_o=1 exactly while the state is SEND.

Decomposition:
- Add flit-type constants `FLIT_TYPE_HEAD/BODY/TAIL/HEADTAIL and `FLIT_TYPE_BITS to NIC-defines.v.
- Reuse clog2 from NIC_utils.vh.
- One sub-module: credit_counter (parameters N_CREDITS, N_BITS_CREDIT; inputs inc/dec; outputs count, has_credit, err).
- FSM, packet register and flit mux stay in flits_sender.

Test Plan:
- Single flit: reset, N_CREDITS=4, packet flit0=64'hFF3, request held.
  - Response: grant pulse one cycle; next cycle out_link_o=64'hFF3 with is_valid_o=1 for one cycle; counter=3; busy_o falls.
- Five flits 64'h00, 64'h11, 64'h21, 64'h31, 64'h72 with 4 credits and no credit pulses.
  - Response: 00, 11, 21, 31 valid on four consecutive cycles, then is_valid_o=0.
  - After one credit pulse: 72 is sent the next cycle; FSM returns to IDLE.
- Simultaneous credit and send during the five-flit packet at counter=2.
  - Response: counter stays 2; no bubble in the flit stream.
- Max-length packet of `MAX_PACKET_LENGHT body flits (type 01), no tail.
  - Response: all flits sent in order, then IDLE; the next request is granted.
- Request pulsed during SEND.
  - Response: no grant until after the tail; with the request held, the grant occurs the cycle after IDLE is re-entered.
- Reset mid-packet after 2 flits, and extra credit at counter=N_CREDITS.
  - Reset: is_valid_o drops asynchronously and the counter returns to N_CREDITS.
  - Extra credit (separate run): credit_err_o goes high and stays high until reset.
